// File: rtl/spi_shift_engine.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// spi_shift_engine
//   SPI data-path shifter with runtime clock phase (cpha) and bit order
//   (lsbfe). The SPI controller supplies SCK edge strobes. The register file
//   drives the SPDR write path and reads the receive buffer.
//   One shift register carries both directions. The outgoing bit is taken
//   from one end and the incoming bit enters at the other end, so after
//   DWIDTH samples the register holds exactly the received word.
//
// Ports
//   Shift_clk   system clock (rising edge)
//   rst         asynchronous reset, active-low
//   lead_edge   SCK leading-edge strobe (one cycle)
//   trail_edge  SCK trailing-edge strobe (one cycle)
//   start       begin a transfer from the TX holding register
//   cpha        0: sample on leading / shift on trailing, 1: the opposite
//   lsbfe       1: LSB first, 0: MSB first
//   SPDR_wr_en  write SPDR_in into the TX holding register
//   SPDR_in     TX data
//   Data_in     serial input (MISO)
//   spif_clr    clear spif
//   wcol_clr    clear wcol
//   Data_out    serial output (MOSI)
//   SPDR_out    receive buffer, last completed word
//   busy        transfer in progress
//   done        one-cycle completion pulse
//   spif        sticky transfer-complete flag
//   wcol        sticky write-collision flag
// ---------------------------------------------------------------------------
module spi_shift_engine #(
  parameter int   DWIDTH    = 8,
  parameter logic IDLE_MOSI = 1'b0
) (
  input  logic              Shift_clk,
  input  logic              rst,
  input  logic              lead_edge,
  input  logic              trail_edge,
  input  logic              start,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic              SPDR_wr_en,
  input  logic [DWIDTH-1:0] SPDR_in,
  input  logic              Data_in,
  input  logic              spif_clr,
  input  logic              wcol_clr,
  output logic              Data_out,
  output logic [DWIDTH-1:0] SPDR_out,
  output logic              busy,
  output logic              done,
  output logic              spif,
  output logic              wcol
);

  localparam int CW = $clog2(DWIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_CMPL = 2'd2
  } state_t;

  state_t            r_state;
  logic [DWIDTH-1:0] r_tx_hold;
  logic [DWIDTH-1:0] r_shift;
  logic [CW-1:0]     r_cnt;
  logic              r_cpha;
  logic              r_lsbfe;
  logic              r_data_out;
  logic [DWIDTH-1:0] r_spdr_out;
  logic              r_busy;
  logic              r_done;
  logic              r_spif;
  logic              r_wcol;

  logic              w_sample;
  logic              w_shift;
  logic [DWIDTH-1:0] w_shift_next;
  logic              w_tx_bit;
  logic              w_last;
  logic [DWIDTH-1:0] w_load;
  logic              w_first_bit;

  // When both strobes arrive in one cycle the leading edge takes priority.
  // The trailing strobe is therefore masked off whenever lead_edge is high.
  assign w_sample = r_cpha ? (trail_edge & ~lead_edge) : lead_edge;
  assign w_shift  = r_cpha ? lead_edge : (trail_edge & ~lead_edge);

  // The received bit enters at the end opposite to the end the TX bit leaves from.
  assign w_shift_next = r_lsbfe ? {Data_in, r_shift[DWIDTH-1:1]}
                                : {r_shift[DWIDTH-2:0], Data_in};
  assign w_tx_bit     = r_lsbfe ? r_shift[0] : r_shift[DWIDTH-1];
  assign w_last       = (r_cnt == CW'(DWIDTH - 1));

  // A write in the same cycle as start supplies the word directly.
  assign w_load      = SPDR_wr_en ? SPDR_in : r_tx_hold;
  assign w_first_bit = lsbfe ? w_load[0] : w_load[DWIDTH-1];

  // Transfer FSM together with its datapath, the flags and the registered outputs
  always_ff @(posedge Shift_clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_tx_hold  <= '0;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_cpha     <= 1'b0;
      r_lsbfe    <= 1'b0;
      r_data_out <= IDLE_MOSI;
      r_spdr_out <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_spif     <= 1'b0;
      r_wcol     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A clear only takes effect when no set event occurs in the same cycle.
      r_spif <= r_spif & ~spif_clr;
      r_wcol <= (r_wcol & ~wcol_clr) | (SPDR_wr_en & r_busy);

      case (r_state)
        ST_IDLE: begin
          if (SPDR_wr_en) begin
            r_tx_hold <= SPDR_in;
          end
          if (start) begin
            r_shift <= w_load;
            r_cpha  <= cpha;
            r_lsbfe <= lsbfe;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_XFER;
            // With cpha=0 the first bit must be on the line before the first sample edge.
            if (!cpha) begin
              r_data_out <= w_first_bit;
            end
          end
        end

        ST_XFER: begin
          if (w_sample) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
              r_state    <= ST_CMPL;
              r_spdr_out <= w_shift_next;
              r_done     <= 1'b1;
              r_spif     <= 1'b1;
            end
          end else if (w_shift) begin
            r_data_out <= w_tx_bit;
          end
        end

        ST_CMPL: begin
          r_busy     <= 1'b0;
          r_data_out <= IDLE_MOSI;
          r_state    <= ST_IDLE;
        end

        default: begin
          r_busy     <= 1'b0;
          r_data_out <= IDLE_MOSI;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign Data_out = r_data_out;
  assign SPDR_out = r_spdr_out;
  assign busy     = r_busy;
  assign done     = r_done;
  assign spif     = r_spif;
  assign wcol     = r_wcol;

endmodule

// File: tb/tb_spi_shift_engine.sv
`timescale 1ns/1ps
module tb_spi_shift_engine;

  localparam int   DW     = 8;
  localparam logic IDLE_V = 1'b0;

  logic          Shift_clk = 1'b0;
  logic          rst;
  logic          lead_edge, trail_edge, start, cpha, lsbfe, SPDR_wr_en;
  logic [DW-1:0] SPDR_in;
  logic          Data_in, spif_clr, wcol_clr;
  logic          Data_out;
  logic [DW-1:0] SPDR_out;
  logic          busy, done, spif, wcol;

  spi_shift_engine #(.DWIDTH(DW), .IDLE_MOSI(IDLE_V)) dut (
    .Shift_clk (Shift_clk),
    .rst       (rst),
    .lead_edge (lead_edge),
    .trail_edge(trail_edge),
    .start     (start),
    .cpha      (cpha),
    .lsbfe     (lsbfe),
    .SPDR_wr_en(SPDR_wr_en),
    .SPDR_in   (SPDR_in),
    .Data_in   (Data_in),
    .spif_clr  (spif_clr),
    .wcol_clr  (wcol_clr),
    .Data_out  (Data_out),
    .SPDR_out  (SPDR_out),
    .busy      (busy),
    .done      (done),
    .spif      (spif),
    .wcol      (wcol)
  );

  always #5 Shift_clk = ~Shift_clk;

  int cyc = 0;
  always @(posedge Shift_clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [DW-1:0] tx;
    logic [DW-1:0] rx;
  } exp_t;

  exp_t          exp_q[$];   // expected MOSI word and SPDR_out, pushed at start
  int            cyc_q[$];   // expected cycle of the done pulse
  logic [DW-1:0] mosi_q[$];  // MOSI word observed by the slave model
  logic [DW-1:0] hold_m;     // model of the TX holding register

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    lead_edge  = 1'b0;
    trail_edge = 1'b0;
    start      = 1'b0;
    SPDR_wr_en = 1'b0;
    spif_clr   = 1'b0;
    wcol_clr   = 1'b0;
  endtask

  // One clock; afterwards the pulses drop and the don't-care inputs get fresh noise.
  task automatic tick();
    @(posedge Shift_clk);
    #1;
    idle_inputs();
    Data_in = 1'($urandom);
    cpha    = 1'($urandom);
    lsbfe   = 1'($urandom);
    SPDR_in = DW'($urandom);
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_Data_out"}, 32'(Data_out), 32'(IDLE_V));
    chk({tag, "_SPDR_out"}, 32'(SPDR_out), 32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
    chk({tag, "_spif"},     32'(spif),     32'd0);
    chk({tag, "_wcol"},     32'(wcol),     32'd0);
  endtask

  task automatic randomize_all();
    lead_edge  = 1'($urandom);
    trail_edge = 1'($urandom);
    start      = 1'($urandom);
    SPDR_wr_en = 1'($urandom);
    spif_clr   = 1'($urandom);
    wcol_clr   = 1'($urandom);
  endtask

  // One complete transfer driven as a slave/controller pair.
  task automatic do_xfer(input logic cp, input logic lf, input bit do_wr, input bit same,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] rx,
                         input int comb_bit, input int coll_bit, input bit clr_at_end);
    logic [DW-1:0] mosi;
    exp_t          e;
    int            idx;
    mosi = '0;
    if (do_wr && !same) begin
      SPDR_wr_en = 1'b1; SPDR_in = wdata; hold_m = wdata;
      tick();
    end
    start = 1'b1; cpha = cp; lsbfe = lf;
    if (do_wr && same) begin
      SPDR_wr_en = 1'b1; SPDR_in = wdata; hold_m = wdata;
    end
    e.tx = hold_m;
    e.rx = rx;
    exp_q.push_back(e);
    tick();
    for (int i = 0; i < DW; i++) begin
      idx = lf ? i : DW - 1 - i;
      gap();
      if (!cp) begin
        lead_edge = 1'b1;
        if (i == comb_bit) trail_edge = 1'b1;
        mosi[idx] = Data_out;
        Data_in   = rx[idx];
        if (i == DW - 1) begin
          cyc_q.push_back(cyc + 1);
          mosi_q.push_back(mosi);
          if (clr_at_end) spif_clr = 1'b1;
        end
        tick();
        gap();
        trail_edge = 1'b1;
        tick();
      end else begin
        lead_edge = 1'b1;
        tick();
        gap();
        trail_edge = 1'b1;
        mosi[idx]  = Data_out;
        Data_in    = rx[idx];
        if (i == DW - 1) begin
          cyc_q.push_back(cyc + 1);
          mosi_q.push_back(mosi);
          if (clr_at_end) spif_clr = 1'b1;
        end
        tick();
      end
      if (i == coll_bit) begin
        SPDR_wr_en = 1'b1; SPDR_in = {DW{1'b1}};
        tick();
        chk("wcol_set", 32'(wcol), 32'd1);
        SPDR_wr_en = 1'b1; SPDR_in = {DW{1'b1}}; wcol_clr = 1'b1;
        tick();
        chk("wcol_set_beats_clr", 32'(wcol), 32'd1);
      end
    end
    repeat (3) tick();
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks the cycle after it.
  exp_t mon_e;
  logic post_done = 1'b0;
  always @(negedge Shift_clk) begin
    if (rst) begin
      if (post_done) begin
        chk("busy_low_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle",      32'(done), 32'd0);
        chk("mosi_idle_after",     32'(Data_out), 32'(IDLE_V));
      end
      if (done) begin
        if (exp_q.size() == 0 || cyc_q.size() == 0 || mosi_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("SPDR_out",     32'(SPDR_out),          32'(mon_e.rx));
          chk("mosi_word",    32'(mosi_q.pop_front()), 32'(mon_e.tx));
          chk("done_latency", 32'(cyc),               32'(cyc_q.pop_front()));
          chk("busy_at_done", 32'(busy),              32'd1);
          chk("spif_at_done", 32'(spif),              32'd1);
        end
      end
      post_done <= done;
    end else begin
      post_done <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b0; SPDR_in = '0; Data_in = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
    hold_m = '0;
    #1;
    check_reset_vals("por");
    tick(); tick();
    rst = 1'b1;
    tick();
    check_reset_vals("por_rel");

    // cpha=0 MSB first, A5 out / 3C in
    do_xfer(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'h3C, -1, -1, 1'b0);
    chk("spif_after_t2", 32'(spif), 32'd1);
    spif_clr = 1'b1;
    tick();
    chk("spif_cleared", 32'(spif), 32'd0);

    // cpha=1 LSB first, 81 out / 7E in
    do_xfer(1'b1, 1'b1, 1'b1, 1'b1, 8'h81, 8'h7E, -1, -1, 1'b0);

    // reset in idle with random inputs
    rst = 1'b0;
    #1;
    check_reset_vals("rst_idle");
    for (int k = 0; k < 3; k++) begin
      randomize_all();
      tick();
      check_reset_vals("rst_hold");
    end
    idle_inputs();
    rst = 1'b1;
    hold_m = '0;
    exp_q.delete();
    tick();
    check_reset_vals("rst_rel");
    // holding register was reset: a transfer without a write sends zero
    do_xfer(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC3, -1, -1, 1'b0);

    // write collision during a 12 transfer
    do_xfer(1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 8'h96, -1, 3, 1'b0);
    chk("wcol_sticky", 32'(wcol), 32'd1);
    do_xfer(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h4B, -1, -1, 1'b0);
    wcol_clr = 1'b1;
    tick();
    chk("wcol_cleared", 32'(wcol), 32'd0);

    // reset after three samples
    SPDR_wr_en = 1'b1; SPDR_in = 8'hE7;
    tick();
    start = 1'b1; cpha = 1'b0; lsbfe = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      lead_edge = 1'b1; Data_in = 1'b1;
      tick();
      trail_edge = 1'b1;
      tick();
    end
    chk("busy_mid_xfer", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    exp_q.delete();
    hold_m = '0;
    tick();
    rst = 1'b1;
    tick();
    do_xfer(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 8'hA9, -1, -1, 1'b0);

    // strobes in idle change nothing
    for (int k = 0; k < 6; k++) begin
      lead_edge = 1'($urandom); trail_edge = 1'($urandom);
      tick();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_mosi", 32'(Data_out), 32'(IDLE_V));
      chk("idle_done", 32'(done), 32'd0);
    end
    // combined lead+trail counts as one sample without a shift
    do_xfer(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h35, 2, -1, 1'b0);
    do_xfer(1'b0, 1'b1, 1'b1, 1'b0, 8'hC6, 8'h1F, 0, -1, 1'b0);

    // randomized transfers
    for (int n = 0; n < 20; n++) begin
      logic cp;
      cp = 1'($urandom);
      do_xfer(cp, 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
              DW'($urandom), DW'($urandom),
              (!cp && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, DW - 1)) : -1,
              -1, 1'($urandom));
    end

    repeat (5) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
